// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: word type, fetch FSM states,
// IF/ID bundle and reset defaults.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HELD,
    ST_DROP
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } if_id_t;

  localparam word_t RESET_PC_DEF  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between
// the fetch stage and instruction memory.
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_pc_target_mux.sv
// Redirect decision and target select for decode-stage
// control transfers (JR over J over taken branch).
module pc_target_mux
  import cpu_pkg::*;
(
  input  logic  valid,
  input  logic  stall,
  input  logic  z,
  input  logic  j,
  input  logic  jr,
  input  word_t branch_addr,
  input  word_t jump_addr,
  input  word_t jr_addr,
  output word_t target,
  output logic  redirect
);

  always_comb begin
    target = branch_addr;
    priority case (1'b1)
      jr:      target = jr_addr;
      j:       target = jump_addr;
      default: target = branch_addr;
    endcase
  end

  // operands are stale during a load-use stall
  assign redirect = valid & ~stall & (jr | j | z);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem handshake and the
// IF/ID register, with stall hold and redirect flush.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  Stall,
  input  logic  Z,
  input  logic  J,
  input  logic  JR,
  input  word_t BranchAddr,
  input  word_t JumpAddr,
  input  word_t JrAddr,
  if_fetch_unit_if.master imem,
  output word_t Instruction_id,
  output word_t NextPC_id,
  output logic  valid_id
);

  fetch_state_t state;
  word_t        pc;
  word_t        addr_q;
  logic         req_q;
  if_id_t       id_q;
  if_id_t       hold_q;
  logic         valid_q;

  word_t pc_inc;
  word_t target;
  logic  redirect;
  logic  ack;
  word_t rdata;

  assign pc_inc = pc + 32'd4;
  assign ack    = imem.imem_ack;
  assign rdata  = imem.imem_rdata;

  pc_target_mux u_mux (
    .valid       (valid_q),
    .stall       (Stall),
    .z           (Z),
    .j           (J),
    .jr          (JR),
    .branch_addr (BranchAddr),
    .jump_addr   (JumpAddr),
    .jr_addr     (JrAddr),
    .target      (target),
    .redirect    (redirect)
  );

  // addr_q doubles as the drop address while in ST_DROP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      id_q    <= '{instr: NOP_INSTR, npc: 32'h0};
      hold_q  <= '{instr: NOP_INSTR, npc: 32'h0};
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state  <= ST_REQ;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        ST_REQ: begin
          if (ack && redirect) begin
            pc         <= target;
            addr_q     <= target;
            id_q.instr <= NOP_INSTR;
            valid_q    <= 1'b0;
          end else if (ack && Stall) begin
            hold_q <= '{instr: rdata, npc: pc_inc};
            pc     <= pc_inc;
            req_q  <= 1'b0;
            state  <= ST_HELD;
          end else if (ack) begin
            id_q    <= '{instr: rdata, npc: pc_inc};
            valid_q <= 1'b1;
            pc      <= pc_inc;
            addr_q  <= pc_inc;
          end else if (redirect) begin
            pc         <= target;
            id_q.instr <= NOP_INSTR;
            valid_q    <= 1'b0;
            state      <= ST_DROP;
          end else if (!Stall) begin
            id_q.instr <= NOP_INSTR;
            valid_q    <= 1'b0;
          end
        end
        ST_HELD: begin
          if (!Stall) begin
            state <= ST_REQ;
            req_q <= 1'b1;
            if (redirect) begin
              pc         <= target;
              addr_q     <= target;
              id_q.instr <= NOP_INSTR;
              valid_q    <= 1'b0;
            end else begin
              addr_q  <= pc;
              id_q    <= hold_q;
              valid_q <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          id_q.instr <= NOP_INSTR;
          valid_q    <= 1'b0;
          if (ack) begin
            state  <= ST_REQ;
            addr_q <= pc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = word_align(addr_q);

  assign Instruction_id = id_q.instr;
  assign NextPC_id      = id_q.npc;
  assign valid_id       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit against an
// instruction-stream reference model.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  Stall, Z, J, JR;
  word_t BranchAddr, JumpAddr, JrAddr;
  word_t Instruction_id, NextPC_id;
  logic  valid_id;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Stall          (Stall),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .BranchAddr     (BranchAddr),
    .JumpAddr       (JumpAddr),
    .JrAddr         (JrAddr),
    .imem           (bus),
    .Instruction_id (Instruction_id),
    .NextPC_id      (NextPC_id),
    .valid_id       (valid_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic  m_ack;
  word_t m_rdata;
  int    wcnt, lat, delivered;
  logic  held, prev_req, prev_ack;
  word_t prev_addr, exp_next, cur_pc;

  task automatic chk(input string tag, input word_t obs,
                     input word_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic a, input word_t d);
    bus.imem_ack   = a;
    bus.imem_rdata = d;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
  endtask

  function automatic word_t word_at(input word_t a);
    return (a * 32'h9E37_79B9) ^ 32'h5BD1_E995;
  endfunction

  function automatic word_t rnd_target();
    word_t t;
    t = $urandom;
    if ($urandom_range(0, 7) == 0) t[31:4] = 28'hFFF_FFFF;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    Stall = 1'b0; Z = 1'b0; J = 1'b0; JR = 1'b0;
    BranchAddr = '0; JumpAddr = '0; JrAddr = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;

    // reset values
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    chk("rst_instr", Instruction_id, 32'h0);
    chk("rst_npc", NextPC_id, 32'h0);
    chk1("rst_valid", valid_id, 1'b0);
    chk1("rst_req", bus.imem_req, 1'b0);
    rst_n = 1'b1;

    // first fetches with single-cycle acks
    tick(1'b0, 32'h0);
    chk1("req0", bus.imem_req, 1'b1);
    chk("addr0", bus.imem_addr, 32'h0);
    tick(1'b1, 32'h2001_0005);
    chk("i0", Instruction_id, 32'h2001_0005);
    chk("npc0", NextPC_id, 32'h4);
    chk1("v0", valid_id, 1'b1);
    chk("addr4", bus.imem_addr, 32'h4);
    tick(1'b1, 32'h2002_0007);
    chk("i1", Instruction_id, 32'h2002_0007);
    chk("npc1", NextPC_id, 32'h8);
    chk("addr8", bus.imem_addr, 32'h8);

    // taken branch from the instruction at 0x8
    tick(1'b1, 32'h1111_0008);
    chk("i2", Instruction_id, 32'h1111_0008);
    Z = 1'b1; BranchAddr = 32'h40;
    tick(1'b1, 32'h3333_000C);
    Z = 1'b0;
    chk("br_nop", Instruction_id, 32'h0);
    chk1("br_v", valid_id, 1'b0);
    chk("br_addr", bus.imem_addr, 32'h40);
    tick(1'b1, 32'h4444_0040);
    chk("br_tgt", Instruction_id, 32'h4444_0040);
    chk("br_npc", NextPC_id, 32'h44);

    // load-use stall with an ack arriving
    Stall = 1'b1;
    tick(1'b1, 32'h8C22_0000);
    chk("st_hold0", Instruction_id, 32'h4444_0040);
    chk1("st_req0", bus.imem_req, 1'b0);
    tick(1'b0, 32'h0);
    chk("st_hold1", Instruction_id, 32'h4444_0040);
    chk1("st_req1", bus.imem_req, 1'b0);
    Stall = 1'b0;
    tick(1'b0, 32'h0);
    chk("st_rel", Instruction_id, 32'h8C22_0000);
    chk("st_npc", NextPC_id, 32'h48);
    chk("st_addr", bus.imem_addr, 32'h48);

    // jump held off by stall
    Stall = 1'b1; J = 1'b1; JumpAddr = 32'h100;
    tick(1'b1, 32'h5555_0048);
    chk("js_hold", Instruction_id, 32'h8C22_0000);
    tick(1'b0, 32'h0);
    chk1("js_req", bus.imem_req, 1'b0);
    Stall = 1'b0;
    tick(1'b0, 32'h0);
    J = 1'b0;
    chk("js_addr", bus.imem_addr, 32'h100);
    chk1("js_v", valid_id, 1'b0);
    tick(1'b1, 32'h6666_0100);
    chk("js_tgt", Instruction_id, 32'h6666_0100);

    // redirect while a slow fetch is outstanding
    JR = 1'b1; JrAddr = 32'h200;
    tick(1'b0, 32'h0);
    JR = 1'b0;
    chk("dr_addr0", bus.imem_addr, 32'h104);
    chk1("dr_v0", valid_id, 1'b0);
    tick(1'b0, 32'h0);
    chk("dr_addr1", bus.imem_addr, 32'h104);
    tick(1'b1, 32'h7777_0104);
    chk("dr_addr2", bus.imem_addr, 32'h200);
    chk1("dr_v2", valid_id, 1'b0);
    tick(1'b1, 32'h7777_0200);
    chk("dr_tgt", Instruction_id, 32'h7777_0200);
    chk("dr_npc", NextPC_id, 32'h204);

    // PC wrap at the top of the address space
    JR = 1'b1; JrAddr = 32'hFFFF_FFFC;
    tick(1'b1, 32'hDEAD_0204);
    JR = 1'b0;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick(1'b1, 32'h9999_FFFC);
    chk("wr_instr", Instruction_id, 32'h9999_FFFC);
    chk("wr_npc", NextPC_id, 32'h0);
    chk("wr_next", bus.imem_addr, 32'h0);

    // reset with a request outstanding
    tick(1'b0, 32'h0);
    rst_n = 1'b0;
    tick(1'b0, 32'h0);
    chk("mr_instr", Instruction_id, 32'h0);
    chk("mr_npc", NextPC_id, 32'h0);
    chk1("mr_valid", valid_id, 1'b0);
    chk1("mr_req", bus.imem_req, 1'b0);
    rst_n = 1'b1;
    tick(1'b1, 32'hBAD0_0000);
    chk1("mr_req1", bus.imem_req, 1'b1);
    chk("mr_pc", bus.imem_addr, 32'h0);
    chk1("mr_v1", valid_id, 1'b0);

    // randomized run against the instruction-stream model
    rst_n = 1'b0;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    rst_n = 1'b1;
    exp_next = RESET_PC_DEF;
    cur_pc = '0;
    held = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    wcnt = 0;
    lat = int'($urandom_range(1, 3));
    delivered = 0;

    for (int c = 0; c < 3000; c++) begin
      if (prev_req && !prev_ack) begin
        chk1("hs_req", bus.imem_req, 1'b1);
        chk("hs_addr", bus.imem_addr, prev_addr);
      end
      if (bus.imem_req)
        chk("hs_align", {30'h0, bus.imem_addr[1:0]}, 32'h0);
      if (held) begin
        chk1("rs_valid", valid_id, 1'b1);
        chk("rs_instr", Instruction_id,
            word_at(word_align(cur_pc)));
        chk("rs_npc", NextPC_id, cur_pc + 32'd4);
      end else if (valid_id) begin
        chk("rs_seq", Instruction_id,
            word_at(word_align(exp_next)));
        chk("rs_seqnpc", NextPC_id, exp_next + 32'd4);
        cur_pc = exp_next;
        exp_next = exp_next + 32'd4;
        delivered++;
      end

      Stall = valid_id && ($urandom_range(0, 3) == 0);
      Z  = ($urandom_range(0, 5) == 0);
      J  = ($urandom_range(0, 7) == 0);
      JR = ($urandom_range(0, 7) == 0);
      BranchAddr = rnd_target();
      JumpAddr   = rnd_target();
      JrAddr     = rnd_target();

      held = valid_id && Stall;
      if (valid_id && !Stall && (JR || J || Z))
        exp_next = JR ? JrAddr : (J ? JumpAddr : BranchAddr);

      m_ack = 1'b0;
      m_rdata = $urandom;
      prev_req = bus.imem_req;
      prev_addr = bus.imem_addr;
      if (bus.imem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          m_ack = 1'b1;
          m_rdata = word_at(bus.imem_addr);
          wcnt = 0;
          lat = int'($urandom_range(1, 3));
        end
      end
      prev_ack = m_ack;
      tick(m_ack, m_rdata);
    end
    chk1("progress", delivered >= 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that feeds the decode stage.
- Owns the PC, the instruction-memory request handshake and the IF/ID pipeline register; drives `Instruction_id` / `NextPC_id`.
- Consumes decode-stage results: `Stall`, branch-taken `Z`, `J`, `JR`, `BranchAddr`, `JumpAddr`, `JrAddr`.
- Tolerates variable-latency instruction memory; flushes on redirects and holds the fetched word during load-use stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or bubble.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- Stall  in  1  load-use hazard from decode; 1 = hold PC and IF/ID.
- Z  in  1  conditional branch taken (decode instruction).
- J  in  1  jump (j/jal) in decode.
- JR  in  1  jump-register in decode.
- BranchAddr  in  32  branch target.
- JumpAddr  in  32  jump target.
- JrAddr  in  32  register jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid when high.
- imem_rdata  in  32  fetched instruction.
- Instruction_id  out  32  IF/ID instruction.
- NextPC_id  out  32  IF/ID fetch address + 4.
- valid_id  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst_n=0 at posedge): PC=RESET_PC, Instruction_id=NOP_INSTR, NextPC_id=0, valid_id=0, imem_req=0, hold buffer empty, state=IDLE.
- redirect = valid_id & ~Stall & (JR|J|Z).
  - Target priority: JR→JrAddr, else J→JumpAddr, else BranchAddr.
  - Stall suppresses redirect, because branch operands are stale during a load-use stall.
- Handshake:
  - imem_req and imem_addr stay stable until imem_ack.
  - Exactly one request is outstanding at a time; no cancellation.
  - The ack may arrive in the first request cycle (minimum latency 1).
- State IDLE: imem_req=0; next cycle → REQ.
- State REQ: imem_req=1, imem_addr=PC.
  - ack & redirect: discard rdata; PC←target; IF/ID←NOP, valid_id←0; stay REQ.
  - ack & Stall: hold buffer←{rdata, PC+4}; PC←PC+4; IF/ID unchanged; → HELD.
  - ack, no Stall, no redirect: Instruction_id←rdata, NextPC_id←PC+4, valid_id←1; PC←PC+4; stay REQ.
  - no ack & redirect: drop_addr←PC; PC←target; IF/ID←NOP, valid_id←0; → DROP.
  - no ack & Stall: IF/ID unchanged.
  - no ack, no Stall: IF/ID←NOP, valid_id←0 (bubble).
- State HELD: imem_req=0.
  - Stall=1: hold everything.
  - Stall=0 & redirect: discard buffer; PC←target; IF/ID←NOP, valid_id←0; → REQ.
  - Stall=0, no redirect: IF/ID←buffer, valid_id←1; → REQ.
- State DROP: imem_req=1, imem_addr=drop_addr.
  - IF/ID←NOP, valid_id←0 every cycle.
  - Further redirects are impossible (valid_id=0).
  - On ack: discard rdata; → REQ, which fetches at PC.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - Targets are used as given; bits [1:0] of imem_addr are forced to 0.
- Reset mid-request: the outstanding ack is ignored; state returns to IDLE.
  - The memory must not ack more than 2 cycles after reset release (system guarantee).
- Throughput: 1 instruction/cycle with single-cycle acks.
  - Taken redirect costs 1 bubble with a 1-cycle memory, or latency+1 with an outstanding miss.

Decomposition:
- Shared package `cpu_pkg`:
  - fetch state enum (IDLE, REQ, HELD, DROP);
  - NOP_INSTR and RESET_PC defaults;
  - 32-bit word typedef.
- One sub-module: `pc_target_mux`, combinational JR/J/Z priority select producing target and redirect.
- Everything else stays in this module.

Test Plan:
- Reset then 1-cycle acks returning 0x2001_0005, 0x2002_0007 → imem_addr 0x0, 0x4, 0x8; Instruction_id 0x2001_0005 with NextPC_id 0x4, then 0x2002_0007 with NextPC_id 0x8; valid_id=1.
- Instruction at 0x8 in ID with Z=1, BranchAddr=0x40 → IF/ID=NOP for one cycle, next imem_addr=0x40, and the word fetched at 0xC is never presented.
- Stall=1 for 2 cycles while an ack arrives with 0x8C22_0000 → Instruction_id frozen, state HELD, imem_req=0; after Stall falls, Instruction_id=0x8C22_0000.
- Stall=1 together with J=1, JumpAddr=0x100 → no redirect while stalled; once Stall=0 and J is still 1, the PC becomes 0x100.
- 3-cycle memory latency with JR=1, JrAddr=0x200 before the ack → DROP; imem_addr stays on the old address until the ack, that word is discarded, then the request goes to 0x200.
- PC=0xFFFF_FFFC fetch → next imem_addr=0x0. Assert rst_n=0 mid-request → all outputs at reset values the next cycle, PC=RESET_PC.
